operand_entry: RTL and testbench

Pushbutton front end for the 3-bit adder/7-segment display stage. Three raw buttons (increment A, increment B, clear) are synchronised and debounced, and turned into single press events. Two registered 3-bit operand counters drive the display stage's a0..a2 and b0..b2 operand inputs directly. Optional auto-repeat lets a held button step an operand continuously.

---
 rtl/operand_entry_pkg.sv | 14 +
 rtl/button_debounce.sv | 89 ++++++++
 rtl/operand_entry.sv | 93 +++++++++
 tb/tb_operand_entry.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/operand_entry_pkg.sv
// operand_entry_pkg: shared types for the pushbutton operand front end.
// Holds the debounce state encoding and the operand width.
package operand_entry_pkg;

  localparam int OPERAND_W = 3;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } db_state_t;

endpackage

// File: rtl/button_debounce.sv
// button_debounce: 2-flop synchroniser plus debounce/auto-repeat FSM.
// Ports: clk, rst (sync, high), btn_raw (async), press_evt (1-cycle pulse).
module button_debounce
  import operand_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_CYCLES   = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press_evt
);

  localparam int CW_RAW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam int RW_RAW = $clog2(REPEAT_CYCLES + 1);
  localparam int RW     = (RW_RAW < 1) ? 1 : RW_RAW;

  localparam logic [CW-1:0] CNT_LAST =
    CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RPT_LAST =
    RW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
  localparam bit RPT_EN = (REPEAT_CYCLES != 0);

  logic          sync1;
  logic          sync2;
  db_state_t     state;
  logic [CW-1:0] cnt;
  logic [RW-1:0] rpt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      state     <= RELEASED;
      cnt       <= '0;
      rpt       <= '0;
      press_evt <= 1'b0;
    end else begin
      sync1     <= btn_raw;
      sync2     <= sync1;
      press_evt <= 1'b0;
      unique case (state)
        RELEASED: begin
          if (sync2) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!sync2) begin
            state <= RELEASED;
          end else if (cnt == CNT_LAST) begin
            state     <= PRESSED;
            press_evt <= 1'b1;
            rpt       <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        PRESSED: begin
          if (!sync2) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end else if (RPT_EN && rpt == RPT_LAST) begin
            press_evt <= 1'b1;
            rpt       <= '0;
          end else begin
            rpt <= rpt + RW'(1);
          end
        end
        RELEASE_WAIT: begin
          // a bounce back high resumes the hold without an event
          if (sync2) begin
            state <= PRESSED;
            rpt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= RELEASED;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= RELEASED;
      endcase
    end
  end

endmodule

// File: rtl/operand_entry.sv
// operand_entry: debounced buttons stepping two 3-bit operand counters.
// Ports: clk, rst, btn_a/btn_b/btn_clr in; a0..a2, b0..b2, changed out.
module operand_entry
  import operand_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_CYCLES   = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_a,
  input  logic btn_b,
  input  logic btn_clr,
  output logic a0,
  output logic a1,
  output logic a2,
  output logic b0,
  output logic b1,
  output logic b2,
  output logic changed
);

  logic                 evt_a;
  logic                 evt_b;
  logic                 evt_clr;
  logic [OPERAND_W-1:0] opa;
  logic [OPERAND_W-1:0] opb;
  logic [OPERAND_W-1:0] opa_n;
  logic [OPERAND_W-1:0] opb_n;
  logic                 diff;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES)
  ) u_db_a (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_a),
    .press_evt(evt_a)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES)
  ) u_db_b (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_b),
    .press_evt(evt_b)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_CYCLES  (0)
  ) u_db_clr (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_clr),
    .press_evt(evt_clr)
  );

  // clear dominates; A and B step independently
  always_comb begin
    opa_n = opa;
    opb_n = opb;
    if (evt_clr) begin
      opa_n = '0;
      opb_n = '0;
    end else begin
      if (evt_a) opa_n = opa + OPERAND_W'(1);
      if (evt_b) opb_n = opb + OPERAND_W'(1);
    end
  end

  // diff marks the update edge; changed follows one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      opa     <= '0;
      opb     <= '0;
      diff    <= 1'b0;
      changed <= 1'b0;
    end else begin
      opa     <= opa_n;
      opb     <= opb_n;
      diff    <= (opa_n != opa) || (opb_n != opb);
      changed <= diff;
    end
  end

  assign {a2, a1, a0} = opa;
  assign {b2, b1, b0} = opb;

endmodule

// File: tb/tb_operand_entry.sv
// tb_operand_entry: directed vectors for operand_entry (DEBOUNCE=4).
// Second instance with REPEAT=8 covers auto-repeat.
module tb_operand_entry;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_a = 1'b0;
  logic btn_b = 1'b0;
  logic btn_clr = 1'b0;

  logic a0, a1, a2, b0, b1, b2, chg;
  logic ra0, ra1, ra2, rb0, rb1, rb2, rchg;

  int nvec = 0;
  int nerr = 0;
  int nchg = 0;
  int rnchg = 0;

  always #5 clk = ~clk;

  operand_entry #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_CYCLES  (0)
  ) dut (
    .clk(clk), .rst(rst),
    .btn_a(btn_a), .btn_b(btn_b), .btn_clr(btn_clr),
    .a0(a0), .a1(a1), .a2(a2),
    .b0(b0), .b1(b1), .b2(b2),
    .changed(chg)
  );

  operand_entry #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_CYCLES  (8)
  ) dut_rpt (
    .clk(clk), .rst(rst),
    .btn_a(btn_a), .btn_b(btn_b), .btn_clr(btn_clr),
    .a0(ra0), .a1(ra1), .a2(ra2),
    .b0(rb0), .b1(rb1), .b2(rb2),
    .changed(rchg)
  );

  always @(negedge clk) begin
    if (chg === 1'b1) nchg++;
    if (rchg === 1'b1) rnchg++;
  end

  typedef struct {
    logic [31:0] wa;
    logic [31:0] wb;
    logic [31:0] wc;
    int          ea;
    int          eb;
    int          ec;
  } vec_t;

  vec_t tv[19];

  function automatic int av();
    return int'({a2, a1, a0});
  endfunction

  function automatic int bv();
    return int'({b2, b1, b0});
  endfunction

  function automatic int rav();
    return int'({ra2, ra1, ra0});
  endfunction

  function automatic int rbv();
    return int'({rb2, rb1, rb0});
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int base;
    int rbase;

    tv[0] = '{32'h3FF, 32'h0, 32'h0, 1, 0, 1};
    for (int i = 1; i <= 8; i++)
      tv[i] = '{32'h0, 32'h3FF, 32'h0, 1, i % 8, 1};
    tv[9]  = '{32'h7, 32'h0, 32'h0, 1, 0, 0};
    tv[10] = '{32'h6BFF, 32'h0, 32'h0, 2, 0, 1};
    tv[11] = '{32'h3FF, 32'h3FF, 32'h0, 3, 1, 1};
    tv[12] = '{32'h3FF, 32'h0, 32'h0, 4, 1, 1};
    tv[13] = '{32'h3FF, 32'h0, 32'h0, 5, 1, 1};
    tv[14] = '{32'h0, 32'h3FF, 32'h0, 5, 2, 1};
    tv[15] = '{32'h0, 32'h3FF, 32'h0, 5, 3, 1};
    tv[16] = '{32'h3FF, 32'h0, 32'h3FF, 0, 0, 1};
    tv[17] = '{32'h0, 32'h0, 32'h3FF, 0, 0, 0};
    tv[18] = '{32'h0, 32'h5, 32'h0, 0, 0, 0};

    // reset state
    tick(3);
    chk("rst_a", av(), 0);
    chk("rst_b", bv(), 0);
    chk("rst_chg", int'(chg), 0);
    chk("rst_ra", rav(), 0);
    rst = 1'b0;
    tick(2);

    // exact latency: rise after edge k
    btn_a = 1'b1;
    tick(7);
    chk("lat_a_k7", av(), 0);
    tick(1);
    chk("lat_a_k8", av(), 1);
    chk("lat_chg_k8", int'(chg), 0);
    tick(1);
    chk("lat_chg_k9", int'(chg), 1);
    chk("lat_b_k9", bv(), 0);
    tick(1);
    chk("lat_chg_k10", int'(chg), 0);
    btn_a = 1'b0;
    tick(20);

    // reset clears a nonzero operand
    rst = 1'b1;
    tick(2);
    chk("rst2_a", av(), 0);
    rst = 1'b0;
    tick(2);

    // table of button waveforms
    for (int i = 0; i < 19; i++) begin
      base = nchg;
      for (int c = 0; c < 32; c++) begin
        btn_a   = tv[i].wa[c];
        btn_b   = tv[i].wb[c];
        btn_clr = tv[i].wc[c];
        tick(1);
      end
      chk($sformatf("v%0d_a", i), av(), tv[i].ea);
      chk($sformatf("v%0d_b", i), bv(), tv[i].eb);
      chk($sformatf("v%0d_chg", i), nchg - base, tv[i].ec);
    end

    // reset mid-PRESS_WAIT, button held through release
    btn_b = 1'b1;
    tick(4);
    rst = 1'b1;
    tick(1);
    chk("mid_rst1_out", av() + bv() + int'(chg), 0);
    tick(1);
    chk("mid_rst2_out", av() + bv() + int'(chg), 0);
    rst = 1'b0;
    tick(2);
    chk("mid_b_k8", bv(), 0);
    tick(5);
    chk("mid_b_k13", bv(), 0);
    tick(1);
    chk("mid_b_k14", bv(), 1);
    btn_b = 1'b0;
    tick(20);

    // auto-repeat on second instance
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
    rbase = rnchg;
    btn_a = 1'b1;
    tick(44);
    btn_a = 1'b0;
    tick(20);
    chk("rpt_a", rav(), 5);
    chk("rpt_chg", rnchg - rbase, 5);
    chk("rpt_b", rbv(), 0);

    // held clear fires once; a later A press survives
    rbase = rnchg;
    btn_clr = 1'b1;
    tick(15);
    btn_a = 1'b1;
    tick(10);
    btn_a = 1'b0;
    tick(15);
    btn_clr = 1'b0;
    tick(20);
    chk("rclr_a", rav(), 1);
    chk("rclr_chg", rnchg - rbase, 2);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
